// File: rtl/traffic_lamp_driver.sv
// -----------------------------------------------------------------------------
// traffic_lamp_driver
//
// Receive-side lamp driver for the intersection controller. The 4-bit phase
// code is registered, checked against the legal controller sequence and
// decoded into one-hot {red, yellow, green} drives for four lanes. Illegal
// codes, illegal transitions and over-long greens latch a fault and switch
// all lamps to a flashing-red pattern until the operator acknowledges.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   light_signal phase code (1 NS1_G, 2 NS1_Y, 3 NS2_G, 4 NS2_Y,
//                5 EW1_G, 6 EW1_Y, 7 EW2_G, 8 EW2_Y)
//   fault_clear  operator acknowledge, honoured only while faulted
//   ns1_lamp, ns2_lamp, ew1_lamp, ew2_lamp
//                registered one-hot {red, yellow, green} lane drives
//   running      high while the sequence is being tracked normally
//   fault        latched fault flag
//   fault_cause  00 none, 01 illegal code, 10 illegal transition,
//                11 green timeout
// -----------------------------------------------------------------------------
module traffic_lamp_driver #(
    parameter int STARTUP_CYCLES = 4,
    parameter int MAX_GREEN      = 255,
    parameter int FLASH_HALF     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] light_signal,
    input  logic       fault_clear,
    output logic [2:0] ns1_lamp,
    output logic [2:0] ns2_lamp,
    output logic [2:0] ew1_lamp,
    output logic [2:0] ew2_lamp,
    output logic       running,
    output logic       fault,
    output logic [1:0] fault_cause
);

    localparam int SW = $clog2(STARTUP_CYCLES + 1);
    localparam int GW = $clog2(MAX_GREEN + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_CODE    = 2'b01;
    localparam logic [1:0] CAUSE_TRANS   = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_STARTUP,
        ST_SYNC,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         code_q;
    logic [3:0]         prev_q, prev_d;
    logic [SW-1:0]      start_cnt_q, start_cnt_d;
    logic [GW-1:0]      green_cnt_q, green_cnt_d;
    logic [FW-1:0]      flash_cnt_q, flash_cnt_d;
    logic               flash_on_q, flash_on_d;
    logic [3:0][2:0]    lamps_q, lamps_d;
    logic               running_q, running_d;
    logic               fault_q, fault_d;
    logic [1:0]         cause_q, cause_d;

    // Sequence checking terms, only meaningful while in RUN.
    logic [3:0] succ;
    logic [3:0] code_m1;
    logic       code_bad;
    logic       is_hold;
    logic       is_adv;

    always_comb begin
        succ     = (prev_q == 4'd8) ? 4'd1 : prev_q + 4'd1;
        code_m1  = code_q - 4'd1;
        code_bad = (code_q == 4'd0) || (code_q > 4'd8);
        // Greens are the odd codes; only a green may be held.
        is_hold  = prev_q[0] && (code_q == prev_q);
        is_adv   = (code_q == succ);
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        prev_d      = prev_q;
        start_cnt_d = start_cnt_q;
        green_cnt_d = green_cnt_q;
        flash_cnt_d = flash_cnt_q;
        flash_on_d  = flash_on_q;
        lamps_d     = {4{LAMP_RED}};
        running_d   = running_q;
        fault_d     = fault_q;
        cause_d     = cause_q;

        unique case (state_q)
            ST_STARTUP: begin
                if (start_cnt_q == SW'(STARTUP_CYCLES - 1)) begin
                    state_d     = ST_SYNC;
                    start_cnt_d = '0;
                end else begin
                    start_cnt_d = start_cnt_q + 1'b1;
                end
            end

            ST_SYNC: begin
                if (code_q == 4'd1) begin
                    state_d     = ST_RUN;
                    running_d   = 1'b1;
                    prev_d      = 4'd1;
                    green_cnt_d = GW'(1);
                    lamps_d[0]  = LAMP_GRN;
                end
            end

            ST_RUN: begin
                // Priority order gives the single recorded cause.
                if (code_bad || !(is_adv || is_hold) ||
                    (is_hold && green_cnt_q == GW'(MAX_GREEN))) begin
                    state_d     = ST_FAULT;
                    running_d   = 1'b0;
                    fault_d     = 1'b1;
                    flash_cnt_d = '0;
                    flash_on_d  = 1'b1;
                    if (code_bad)
                        cause_d = CAUSE_CODE;
                    else if (!(is_adv || is_hold))
                        cause_d = CAUSE_TRANS;
                    else
                        cause_d = CAUSE_TIMEOUT;
                end else begin
                    prev_d = code_q;
                    if (is_hold)
                        green_cnt_d = green_cnt_q + 1'b1;
                    else if (code_q[0])
                        green_cnt_d = GW'(1);
                    else
                        green_cnt_d = '0;
                    lamps_d[code_m1[2:1]] = code_q[0] ? LAMP_GRN : LAMP_YEL;
                end
            end

            ST_FAULT: begin
                if (fault_clear) begin
                    state_d     = ST_SYNC;
                    fault_d     = 1'b0;
                    cause_d     = CAUSE_NONE;
                    flash_cnt_d = '0;
                    flash_on_d  = 1'b1;
                end else begin
                    // Entry cycle counted as the first of the lit half.
                    if (flash_cnt_q == FW'(FLASH_HALF - 1)) begin
                        flash_cnt_d = '0;
                        flash_on_d  = ~flash_on_q;
                    end else begin
                        flash_cnt_d = flash_cnt_q + 1'b1;
                    end
                    lamps_d = flash_on_d ? {4{LAMP_RED}} : {4{LAMP_OFF}};
                end
            end

            default: state_d = ST_STARTUP;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q     <= ST_STARTUP;
            code_q      <= '0;
            prev_q      <= '0;
            start_cnt_q <= '0;
            green_cnt_q <= '0;
            flash_cnt_q <= '0;
            flash_on_q  <= 1'b1;
            lamps_q     <= {4{LAMP_RED}};
            running_q   <= 1'b0;
            fault_q     <= 1'b0;
            cause_q     <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            code_q      <= light_signal;
            prev_q      <= prev_d;
            start_cnt_q <= start_cnt_d;
            green_cnt_q <= green_cnt_d;
            flash_cnt_q <= flash_cnt_d;
            flash_on_q  <= flash_on_d;
            lamps_q     <= lamps_d;
            running_q   <= running_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
        end
    end

    assign ns1_lamp    = lamps_q[0];
    assign ns2_lamp    = lamps_q[1];
    assign ew1_lamp    = lamps_q[2];
    assign ew2_lamp    = lamps_q[3];
    assign running     = running_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;

endmodule

// File: doc/traffic_lamp_driver.md
# traffic_lamp_driver

Receive-side companion to the intersection controller. It samples the 4-bit `light_signal` phase code and decodes it into per-lane red/yellow/green lamp drives for NS1, NS2, EW1 and EW2. It checks every code and every phase transition against the legal controller sequence, watchdogs green dwell time, and forces a latched flashing-red fault mode on any violation. It sits between the controller and the physical lamp outputs.

## Interface
- `STARTUP_CYCLES`, 4: all-red cycles after reset before synchronising (≥1).
- `MAX_GREEN`, 255: maximum consecutive cycles a single green may be displayed (≥1).
- `FLASH_HALF`, 4: cycles per on/off half-period of the fault flash (≥1).
- `clk`  in  1: system clock; single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `light_signal`  in  4: phase code (1 NS1_G, 2 NS1_Y, 3 NS2_G, 4 NS2_Y, 5 EW1_G, 6 EW1_Y, 7 EW2_G, 8 EW2_Y).
- `fault_clear`  in  1: operator acknowledge; honoured only in FAULT.
- `ns1_lamp`, `ns2_lamp`, `ew1_lamp`, `ew2_lamp`  out  3 each: one-hot {red, yellow, green}, registered.
- `running`  out  1: 1 while in RUN.
- `fault`  out  1: latched fault flag.
- `fault_cause`  out  2: 00 none, 01 illegal code, 10 illegal transition, 11 green timeout.

## Operation
- Input stage: `light_signal` registered every cycle into `code_q`. All decisions use `code_q`.
- States: STARTUP → SYNC → RUN → FAULT → SYNC.
- STARTUP:
  - All lamps 100.
  - A counter runs for STARTUP_CYCLES cycles, then the block enters SYNC.
  - Codes are ignored.
- SYNC:
  - All lamps 100; no checking.
  - At the first edge with `code_q`==1, the block enters RUN, NS1 shows 001, `prev`←1, and `green_cnt`←1.
- RUN: each edge evaluates `code_q` against `prev`.
  - `code_q` is 0 or >8: illegal code (01).
  - `prev` is yellow Y (2, 4, 6, 8): only Y+1 is legal (8→1).
  - `prev` is green G (1, 3, 5, 7): G (hold) or G+1 are legal.
  - Any other code: illegal transition (10).
  - Legal hold of G when `green_cnt`==MAX_GREEN: green timeout (11).
  - Otherwise `green_cnt` increments on a hold and loads 1 on entry to a new green.
  - A legal code updates `prev`. The lane named by the code shows 001 (green) or 010 (yellow); all other lanes show 100.
- Violation:
  - Same edge: state←FAULT, `fault`←1, `fault_cause` set, `running`←0, all lamps 100.
  - The offending code is never displayed.
  - Only the first cause is recorded.
- FAULT:
  - Flash counter starts at entry.
  - All lamps 100 for FLASH_HALF cycles (the entry cycle counts as the first), then 000 for FLASH_HALF cycles, repeating.
  - `code_q` is ignored.
  - At an edge with `fault_clear`=1, the block enters SYNC: `fault`←0, `fault_cause`←00, lamps 100, flash counter cleared.
- `fault_clear` outside FAULT has no effect.
- At most one lane is ever non-red. Yellow never follows yellow, and green never follows green across lanes.

## Timing
- Reset values: all lamps 100, `running` 0, `fault` 0, `fault_cause` 00, state STARTUP, counters 0, `code_q` 0, `prev` 0. `rst` overrides all other inputs.
- Latency: a code presented before edge k is in `code_q` after edge k and on the lamps and flags after edge k+1, i.e. 2 cycles.
- Fault latency: same edge as the lamp update would have been (k+1).
- STARTUP lasts exactly STARTUP_CYCLES edges after reset deasserts. SYNC checking begins on the next edge.
- `running` rises on the same edge SYNC→RUN and falls on the fault edge.
- `rst` asserted mid-flash or mid-RUN: next edge gives reset values and STARTUP restarts.
- `fault_clear` coincident with a flash toggle edge: clear wins, lamps 100.
- A code of 1 presented on the clear edge is ignored. SYNC sees it one edge later if it is still present.
- Counter widths: `$clog2(N+1)` for each parameter; no wrap occurs before terminal count.

## Test plan
- Reset, then drive 1,1,2,3,4,5,6,7,8,1:
  - lamps all 100 for 4 cycles;
  - RUN entered on the first qualifying 1;
  - NS1 001,001,010, then NS2 001 …;
  - `running`=1, `fault`=0 throughout.
- In RUN with NS2 green, drive 6:
  - next edge gives `fault`=1, `fault_cause`=10, lamps 100;
  - lamps then 000 after 4 cycles, 100 after 8 cycles.
- In RUN, drive 0 and then 9 (separate runs): `fault_cause`=01, code never displayed.
- MAX_GREEN=3, hold code 5 for 4 cycles: EW1 001 for 3 cycles, then `fault_cause`=11.
- In FAULT, assert `fault_clear`=1 for one cycle with code 3 present: SYNC, lamps 100. Then drive 1: RUN, NS1 001.
- Assert `rst` mid-RUN and mid-FAULT: next edge gives reset values, a full 4-cycle STARTUP, and `fault`=0.
